// File: rtl/arm_regs_pkg.sv
// Shared register-file definitions for the ARMv4 core: index/mask widths,
// their typedefs and the named special-purpose registers.
package arm_regs_pkg;

    localparam int unsigned NREGS = 16;
    localparam int unsigned IDXW  = 4;

    typedef logic [IDXW-1:0]  reg_idx_t;
    typedef logic [NREGS-1:0] reg_mask_t;

    localparam reg_idx_t R_SP = 4'd13;
    localparam reg_idx_t R_LR = 4'd14;
    localparam reg_idx_t R_PC = 4'd15;

endpackage

// File: rtl/decoder_4to16.sv
// Register number to one-hot decoder; a low enable forces an all-zero output.
module decoder_4to16
    import arm_regs_pkg::*;
(
    input  logic      en,
    input  reg_idx_t  idx,
    output reg_mask_t onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: tracks pending writes, flags source hazards and
// issues a registered one-hot write enable on every retire.
module reg_scoreboard #(
    parameter int unsigned NREGS = arm_regs_pkg::NREGS,
    parameter int unsigned IDXW  = arm_regs_pkg::IDXW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [IDXW-1:0]  iss_rd,
    output logic             iss_ready,
    input  logic             ret_valid,
    input  logic [IDXW-1:0]  ret_rd,
    input  logic [IDXW-1:0]  src_a,
    input  logic [IDXW-1:0]  src_b,
    output logic             src_a_busy,
    output logic             src_b_busy,
    output logic [NREGS-1:0] busy_mask,
    output logic [NREGS-1:0] wen_onehot,
    output logic [IDXW:0]    pending_cnt,
    output logic             err_retire
);

    typedef logic [IDXW:0] cnt_t;

    logic [NREGS-1:0] busy_mask_q, busy_mask_d;
    logic [NREGS-1:0] wen_onehot_q, wen_onehot_d;
    cnt_t             pending_cnt_q, pending_cnt_d;
    logic             err_retire_q, err_retire_d;

    logic             iss_fire;
    logic             ret_hit;
    logic [NREGS-1:0] iss_dec;
    logic [NREGS-1:0] ret_dec;

    decoder_4to16 u_iss_dec (
        .en     (iss_fire),
        .idx    (iss_rd),
        .onehot (iss_dec)
    );

    decoder_4to16 u_ret_dec (
        .en     (ret_valid),
        .idx    (ret_rd),
        .onehot (ret_dec)
    );

    // A register retiring this cycle counts as free for both issue and sources.
    always_comb begin
        iss_ready  = !busy_mask_q[iss_rd] || (ret_valid && (ret_rd == iss_rd));
        iss_fire   = iss_valid && iss_ready;
        ret_hit    = ret_valid && busy_mask_q[ret_rd];
        src_a_busy = busy_mask_q[src_a] && !(ret_valid && (ret_rd == src_a));
        src_b_busy = busy_mask_q[src_b] && !(ret_valid && (ret_rd == src_b));
    end

    // Clear before set so a same-register issue/retire leaves the bit busy.
    always_comb begin
        busy_mask_d   = (busy_mask_q & ~ret_dec) | iss_dec;
        wen_onehot_d  = ret_dec;
        err_retire_d  = err_retire_q || (ret_valid && !busy_mask_q[ret_rd]);
        pending_cnt_d = pending_cnt_q;
        case ({iss_fire, ret_hit})
            2'b10:   pending_cnt_d = pending_cnt_q + cnt_t'(1);
            2'b01:   pending_cnt_d = pending_cnt_q - cnt_t'(1);
            default: pending_cnt_d = pending_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask_q   <= '0;
            wen_onehot_q  <= '0;
            pending_cnt_q <= '0;
            err_retire_q  <= 1'b0;
        end else begin
            busy_mask_q   <= busy_mask_d;
            wen_onehot_q  <= wen_onehot_d;
            pending_cnt_q <= pending_cnt_d;
            err_retire_q  <= err_retire_d;
        end
    end

    assign busy_mask   = busy_mask_q;
    assign wen_onehot  = wen_onehot_q;
    assign pending_cnt = pending_cnt_q;
    assign err_retire  = err_retire_q;

    a_cnt_matches_mask: assert property (
        @(posedge clk) disable iff (!rst_n)
        pending_cnt_q == cnt_t'($countones(busy_mask_q))
    );

endmodule
